// File: rtl/seven_segment_to_ascii_capture_if.sv
// Display-bus readback and character-stream interface for seven_segment_to_ascii_capture.
// master = capture block (reads the display bus, drives the character stream); slave = environment.
interface seven_segment_to_ascii_capture_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  char_valid;
    logic                  char_ready;
    logic [7:0]            char_ascii;
    logic [IDX_W-1:0]      char_digit;
    logic                  char_err;
    logic                  overflow;

    modport master (
        input  seg_n, an_n, char_ready,
        output char_valid, char_ascii, char_digit, char_err, overflow
    );

    modport slave (
        output seg_n, an_n, char_ready,
        input  char_valid, char_ascii, char_digit, char_err, overflow
    );
endinterface

// File: rtl/seven_segment_to_ascii_capture.sv
// Recovers ASCII letters from a multiplexed active-low seven-segment bus into a small output FIFO.
// Optional macro SEVSEG_BLANK_EMIT_EN: a newly committed blank digit pushes a space character.
module seven_segment_to_ascii_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    seven_segment_to_ascii_capture_if.master bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + IDX_W + 8;

    localparam logic [NUM_DIGITS-1:0] AN_ONE    = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]      CNT_LIMIT = STABLE_CYCLES;
    localparam logic [PTR_W-1:0]      PTR_ONE   = 1;
    localparam logic [PTR_W:0]        FILL_ONE  = 1;
    localparam logic [PTR_W:0]        FILL_FULL = FIFO_DEPTH;

    typedef enum logic [1:0] {IDLE, TRACK, COMMIT, HOLD} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            lat_pat;
    logic [NUM_DIGITS-1:0] lat_an;
    logic [IDX_W-1:0]      lat_idx;
    logic [IDX_W-1:0]      sample_idx;
    logic                  one_hot;
    logic                  same;
    logic                  lat_load;
    logic                  lp_write;
    logic                  push_req;
    logic [6:0]            last_pat [NUM_DIGITS];

    logic [7:0]            dec_ascii;
    logic                  dec_blank;
    logic                  dec_hit;
    logic [ENT_W-1:0]      push_entry;

    logic [ENT_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        fill;
    logic                  fifo_valid;
    logic                  full;
    logic                  pop;
    logic                  do_push;
    logic [ENT_W-1:0]      head;
    logic                  overflow_q;

    function automatic logic [7:0] glyph_to_ascii(input logic [6:0] pat);
        case (pat)
            7'h77: return 8'h41;  7'h7C: return 8'h42;  7'h39: return 8'h43;
            7'h5E: return 8'h44;  7'h79: return 8'h45;  7'h71: return 8'h46;
            7'h6F: return 8'h47;  7'h74: return 8'h48;  7'h30: return 8'h49;
            7'h1E: return 8'h4A;  7'h75: return 8'h4B;  7'h38: return 8'h4C;
            7'h15: return 8'h4D;  7'h54: return 8'h4E;  7'h3F: return 8'h4F;
            7'h73: return 8'h50;  7'h67: return 8'h51;  7'h33: return 8'h52;
            7'h6D: return 8'h53;  7'h78: return 8'h54;  7'h3E: return 8'h55;
            7'h1C: return 8'h56;  7'h2A: return 8'h57;  7'h76: return 8'h58;
            7'h6E: return 8'h59;  7'h5B: return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    // Same-clock bus: a single register stage, stored active-high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            seg_q <= ~bus.seg_n;
            an_q  <= ~bus.an_n;
        end
    end

    assign one_hot = (an_q != '0) && ((an_q & (an_q - AN_ONE)) == '0);
    assign same    = (an_q == lat_an) && (seg_q == lat_pat);

    always_comb begin
        sample_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_q[i]) sample_idx = IDX_W'(i);
        end
    end

    assign dec_ascii = glyph_to_ascii(lat_pat);
    assign dec_blank = (lat_pat == 7'h00);
    assign dec_hit   = (dec_ascii != 8'h00);

    always_comb begin
        push_entry = '0;
        if (dec_blank)     push_entry = {1'b0, lat_idx, 8'h20};
        else if (dec_hit)  push_entry = {1'b0, lat_idx, dec_ascii};
        else               push_entry = {1'b1, lat_idx, 8'h3F};
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lat_load   = 1'b0;
        lp_write   = 1'b0;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    lat_load   = 1'b1;
                    cnt_next   = CNT_ONE;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (same) begin
                    cnt_next = cnt + CNT_ONE;
                    if (cnt + CNT_ONE == CNT_LIMIT) state_next = COMMIT;
                end else if (one_hot) begin
                    // A new clean sample restarts tracking immediately rather than losing a cycle.
                    lat_load = 1'b1;
                    cnt_next = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                cnt_next   = '0;
                state_next = HOLD;
                if (lat_pat != last_pat[lat_idx]) begin
                    lp_write = 1'b1;
`ifdef SEVSEG_BLANK_EMIT_EN
                    push_req = 1'b1;
`else
                    push_req = !dec_blank;
`endif
                end
            end
            HOLD: begin
                if (!same) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_pat <= '0;
            lat_an  <= '0;
            lat_idx <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (lat_load) begin
                lat_pat <= seg_q;
                lat_an  <= an_q;
                lat_idx <= sample_idx;
            end
        end
    end

    // last_pat advances even when the FIFO drops the entry, so a dropped character is not re-sent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) last_pat[i] <= 7'h00;
        end else if (lp_write) begin
            last_pat[lat_idx] <= lat_pat;
        end
    end

    assign fifo_valid = (fill != '0);
    assign full       = (fill == FILL_FULL);
    assign pop        = fifo_valid && bus.char_ready;
    assign do_push    = push_req && (!full || pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, pop})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
            if (push_req && !do_push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head           = mem[rd_ptr];
    assign bus.char_valid = fifo_valid;
    assign bus.char_ascii = fifo_valid ? head[7:0] : 8'h00;
    assign bus.char_digit = fifo_valid ? head[IDX_W+7:8] : '0;
    assign bus.char_err   = fifo_valid ? head[ENT_W-1] : 1'b0;
    assign bus.overflow   = overflow_q;
endmodule
